// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode legality check and the
// stage-1 bookkeeping record used by the ALU share arbiter.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;

    // What stage 1 must remember about the op currently inside the ALU
    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } s1_t;

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return (op <= ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals of the ALU share arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic                req0;
    logic [ALU_OP_W-1:0] op0;
    logic [WIDTH-1:0]    a0;
    logic [WIDTH-1:0]    b0;
    logic                gnt0;

    logic                req1;
    logic [ALU_OP_W-1:0] op1;
    logic [WIDTH-1:0]    a1;
    logic [WIDTH-1:0]    b1;
    logic                gnt1;

    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [ALU_OP_W-1:0] alu_ctr;
    logic [WIDTH-1:0]    alu_result;
    logic                alu_zero;

    logic                rsp_valid0;
    logic                rsp_valid1;
    logic [WIDTH-1:0]    rsp_result;
    logic                rsp_zero;
    logic                rsp_err;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
        output gnt0, gnt1, alu_a, alu_b, alu_ctr,
               rsp_valid0, rsp_valid1, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
        input  gnt0, gnt1, alu_a, alu_b, alu_ctr,
               rsp_valid0, rsp_valid1, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer only moves when both
// inputs compete, so a lone requester never disturbs the fairness order.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic       prio_r;
    logic [1:0] gnt_s;

    // Grant selection: lone requester wins, contention resolved by prio_r
    always_comb begin
        gnt_s = 2'b00;
        if (reset) begin
            gnt_s = 2'b00;
        end else if (req == 2'b11) begin
            gnt_s = prio_r ? 2'b10 : 2'b01;
        end else begin
            gnt_s = req;
        end
    end

    // Priority pointer flips after every contended grant
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r <= 1'b0;
        end else if (req == 2'b11) begin
            prio_r <= ~prio_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between the EX stage (port 0) and the early-branch
// compare unit (port 1) with a fixed two-cycle, fully pipelined latency.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus
);

    logic [1:0]          req_s;
    logic [1:0]          gnt_s;
    logic                accept_s;
    logic [ALU_OP_W-1:0] win_op_s;
    logic [WIDTH-1:0]    win_a_s;
    logic [WIDTH-1:0]    win_b_s;

    logic [WIDTH-1:0]    alu_a_r;
    logic [WIDTH-1:0]    alu_b_r;
    logic [ALU_OP_W-1:0] alu_ctr_r;
    s1_t                 s1_r;

    logic                rsp_valid0_r;
    logic                rsp_valid1_r;
    logic [WIDTH-1:0]    rsp_result_r;
    logic                rsp_zero_r;
    logic                rsp_err_r;

    assign req_s = {bus.req1, bus.req0};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    assign accept_s = gnt_s[0] | gnt_s[1];

    // Operand/opcode mux steered by the winning grant
    always_comb begin
        win_op_s = bus.op0;
        win_a_s  = bus.a0;
        win_b_s  = bus.b0;
        if (gnt_s[1]) begin
            win_op_s = bus.op1;
            win_a_s  = bus.a1;
            win_b_s  = bus.b1;
        end else begin
            win_op_s = bus.op0;
            win_a_s  = bus.a0;
            win_b_s  = bus.b0;
        end
    end

    // Stage 1: ALU input registers; illegal opcodes run as a harmless add
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_r   <= {WIDTH{1'b0}};
            alu_b_r   <= {WIDTH{1'b0}};
            alu_ctr_r <= ALU_ADD;
            s1_r      <= '{valid: 1'b0, id: 1'b0, err: 1'b0};
        end else begin
            s1_r.valid <= accept_s;
            if (accept_s) begin
                alu_a_r   <= win_a_s;
                alu_b_r   <= win_b_s;
                alu_ctr_r <= alu_op_legal(win_op_s) ? win_op_s : ALU_ADD;
                s1_r.id   <= gnt_s[1];
                s1_r.err  <= ~alu_op_legal(win_op_s);
            end
        end
    end

    // Stage 2: capture the ALU output; errored ops report zero=0 so no branch fires
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid0_r <= 1'b0;
            rsp_valid1_r <= 1'b0;
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
        end else begin
            rsp_valid0_r <= s1_r.valid & ~s1_r.id;
            rsp_valid1_r <= s1_r.valid &  s1_r.id;
            if (s1_r.valid) begin
                rsp_err_r <= s1_r.err;
                if (s1_r.err) begin
                    rsp_result_r <= {WIDTH{1'b0}};
                    rsp_zero_r   <= 1'b0;
                end else begin
                    rsp_result_r <= bus.alu_result;
                    rsp_zero_r   <= bus.alu_zero;
                end
            end
        end
    end

    assign bus.gnt0       = gnt_s[0];
    assign bus.gnt1       = gnt_s[1];
    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_ctr    = alu_ctr_r;
    assign bus.rsp_valid0 = rsp_valid0_r;
    assign bus.rsp_valid1 = rsp_valid1_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then random traffic, checked
// every cycle against a queue-based transaction model and a behavioural ALU.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // External ALU the arbiter feeds
    assign bus_if.alu_result = alu_ref(bus_if.alu_ctr, bus_if.alu_a, bus_if.alu_b);
    assign bus_if.alu_zero   = (bus_if.alu_result == 32'd0);

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] result;
        bit          zero;
        bit          err;
    } rsp_t;

    rsp_t        q[$];
    bit          m_prio;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_ctr;
    bit          m_zero, m_err;

    bit          pend[2];
    logic [2:0]  p_op[2];
    logic [31:0] p_a[2];
    logic [31:0] p_b[2];

    int cyc;
    int checks;
    int failures;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int port, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        pend[port] = 1'b1;
        p_op[port] = op;
        p_a[port]  = a;
        p_b[port]  = b;
    endtask

    // One clock cycle: drive, check everything visible this cycle, advance model
    task automatic step(input bit rst);
        bit   g0e, g1e, v0e, v1e, legal;
        int   w;
        rsp_t r;
        logic [31:0] res;
        @(negedge clk);
        reset       = rst;
        bus_if.req0 = pend[0];
        bus_if.op0  = p_op[0];
        bus_if.a0   = p_a[0];
        bus_if.b0   = p_b[0];
        bus_if.req1 = pend[1];
        bus_if.op1  = p_op[1];
        bus_if.a1   = p_a[1];
        bus_if.b1   = p_b[1];
        #1;
        if (rst) begin
            g0e = 1'b0;
            g1e = 1'b0;
        end else if (pend[0] && pend[1]) begin
            g0e = !m_prio;
            g1e = m_prio;
        end else begin
            g0e = pend[0];
            g1e = pend[1];
        end
        check("gnt0", bus_if.gnt0, g0e);
        check("gnt1", bus_if.gnt1, g1e);
        check("alu_a", bus_if.alu_a, m_a);
        check("alu_b", bus_if.alu_b, m_b);
        check("alu_ctr", bus_if.alu_ctr, m_ctr);

        v0e = 1'b0;
        v1e = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r      = q.pop_front();
            v0e    = !r.port;
            v1e    = r.port;
            m_res  = r.result;
            m_zero = r.zero;
            m_err  = r.err;
        end
        check("rsp_valid0", bus_if.rsp_valid0, v0e);
        check("rsp_valid1", bus_if.rsp_valid1, v1e);
        check("rsp_result", bus_if.rsp_result, m_res);
        check("rsp_zero", bus_if.rsp_zero, m_zero);
        check("rsp_err", bus_if.rsp_err, m_err);

        if (rst) begin
            q.delete();
            m_prio = 1'b0;
            m_a = '0; m_b = '0; m_ctr = '0;
            m_res = '0; m_zero = 1'b0; m_err = 1'b0;
        end else if (g0e || g1e) begin
            w     = g1e ? 1 : 0;
            legal = (p_op[w] <= 3'd4);
            res   = legal ? alu_ref(p_op[w], p_a[w], p_b[w]) : 32'd0;
            m_a   = p_a[w];
            m_b   = p_b[w];
            m_ctr = legal ? p_op[w] : 3'd0;
            q.push_back('{due: cyc + 2, port: g1e, result: res,
                          zero: legal && (res == 32'd0), err: !legal});
            if (pend[0] && pend[1]) m_prio = !m_prio;
            pend[w] = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        m_prio = 1'b0; m_a = '0; m_b = '0; m_ctr = '0;
        m_res = '0; m_zero = 1'b0; m_err = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; p_op[p] = '0; p_a[p] = '0; p_b[p] = '0;
        end
        reset = 1'b1;

        // Reset held with a waiting request, then 5+7 completes in two cycles
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        step(1'b1);
        step(1'b1);
        idle(4);

        // Contention: sub 9-9 on port 0 versus slt 3<4 on port 1
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) set_req(0, ALU_SUB, 32'd9, 32'd9);
            if (!pend[1]) set_req(1, ALU_SLT, 32'd3, 32'd4);
            step(1'b0);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle(3);

        // Lone requester 1, back to back
        set_req(1, ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        step(1'b0);
        set_req(1, ALU_OR, 32'h0000_F000, 32'h0000_000F);
        step(1'b0);
        idle(3);

        // Illegal opcode
        set_req(0, 3'b110, 32'd1, 32'd1);
        step(1'b0);
        idle(3);

        // Reset one cycle after an accept drops the op
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        step(1'b0);
        step(1'b1);
        idle(2);
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        step(1'b0);
        idle(3);

        // Idle gap between two ops
        set_req(0, ALU_SUB, 32'd10, 32'd3);
        step(1'b0);
        idle(3);
        set_req(1, ALU_OR, 32'd0, 32'd0);
        step(1'b0);
        idle(3);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 9) < 6) begin
                    if ($urandom_range(0, 1) == 0)
                        set_req(p, 3'($urandom_range(0, 7)), $urandom, $urandom);
                    else
                        set_req(p, 3'($urandom_range(0, 7)),
                                32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
                end
            end
            step($urandom_range(0, 49) == 0);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
